// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS multiply/divide unit.
package mips_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIX
   } muldiv_state_t;

   localparam int MULDIV_ITERS = 32;

   // Magnitude of a 32-bit operand; unsigned operands pass through untouched.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mips_muldiv_unit.sv
// Iterative 33-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Magnitudes are processed unsigned in a shared 64-bit register; signs are fixed in the last cycle.
module mips_muldiv_unit
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  muldiv_op_t  op,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [5:0] LAST_ITER = 6'(MULDIV_ITERS - 1);

   muldiv_state_t state_q;
   muldiv_op_t    op_q;
   logic [5:0]    cnt_q;
   logic [63:0]   acc_q;
   logic [31:0]   opb_q;
   logic          neg_res_q, neg_rem_q, div0_q;
   logic [31:0]   hi_q, lo_q;
   logic          busy_q, done_q;

   logic          is_signed, is_div_q;
   logic [31:0]   a_mag, b_mag;
   logic [32:0]   mul_sum, div_trial;
   logic [63:0]   step_d, prod_d;
   logic [31:0]   quo, rem;
   logic [31:0]   fix_hi_d, fix_lo_d;

   always_comb begin
      is_signed = (op == OP_MULT) || (op == OP_DIV);
      is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);
      a_mag     = mag32(a, is_signed);
      b_mag     = mag32(b, is_signed);

      // Multiply: acc = {partial product, remaining multiplier bits}.
      // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
      mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
      div_trial = acc_q[63:31] - {1'b0, opb_q};
      if (!is_div_q)
         step_d = {mul_sum, acc_q[31:1]};
      else if (!div_trial[32])
         step_d = {div_trial[31:0], acc_q[30:0], 1'b1};
      else
         step_d = {acc_q[62:0], 1'b0};

      prod_d = neg_res_q ? (~acc_q + 64'd1) : acc_q;
      quo    = acc_q[31:0];
      rem    = acc_q[63:32];
      if (is_div_q) begin
         // Divide by zero leaves |a| in the remainder, so the dividend-sign fix restores a.
         fix_lo_d = div0_q ? 32'hFFFF_FFFF : (neg_res_q ? (~quo + 32'd1) : quo);
         fix_hi_d = neg_rem_q ? (~rem + 32'd1) : rem;
      end else begin
         fix_hi_d = prod_d[63:32];
         fix_lo_d = prod_d[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_MULT;
         cnt_q     <= 6'd0;
         acc_q     <= 64'd0;
         opb_q     <= 32'd0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (mthi) hi_q <= wdata;
               if (mtlo) lo_q <= wdata;
               if (start) begin
                  op_q      <= op;
                  acc_q     <= {32'd0, a_mag};
                  opb_q     <= b_mag;
                  neg_res_q <= is_signed & (a[31] ^ b[31]);
                  neg_rem_q <= is_signed & a[31];
                  div0_q    <= (b == 32'd0);
                  cnt_q     <= 6'd0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc_q <= step_d;
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == LAST_ITER) state_q <= ST_FIX;
            end
            ST_FIX: begin
               hi_q    <= fix_hi_d;
               lo_q    <= fix_lo_d;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: directed vectors, results checked on each done pulse.
module tb_mips_muldiv_unit;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   muldiv_op_t  op;
   logic [31:0] a, b, wdata;
   logic        mthi, mtlo;
   logic        busy, done;
   logic [31:0] hi, lo;

   typedef struct {
      string       nm;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   mips_muldiv_unit dut (
      .clk   (clk),
      .rst   (rst),
      .op    (op),
      .start (start),
      .a     (a),
      .b     (b),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b1 && done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got hi=%08h lo=%08h expected no result", hi, lo);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.nm, "_hi"}, hi, e.hi);
            chk({e.nm, "_lo"}, lo, e.lo);
         end
      end
   end

   // Issue one op at a negedge; optionally inject a second start, an MTHI, or a reset mid-run.
   task automatic run_op(input string nm, input muldiv_op_t o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                         input int hz_start, input int hz_mthi, input logic [31:0] hold_hi,
                         input int rst_at);
      int cyc;
      int busy_cnt;
      bit seen;
      exp_t e;
      @(negedge clk);
      start = 1'b1; op = o; a = av; b = bv;
      if (rst_at < 0) begin
         e.nm = nm; e.hi = eh; e.lo = el;
         sb_q.push_back(e);
      end
      @(negedge clk);
      cyc = 1; busy_cnt = 0; seen = 1'b0;
      while (cyc <= 40) begin
         start = 1'b0; mthi = 1'b0;
         if (rst_at >= 0 && cyc == rst_at + 1) begin
            rst = 1'b1;
            chk({nm, "_rst_busy"}, 32'(busy), 32'd0);
            chk({nm, "_rst_done"}, 32'(done), 32'd0);
            chk({nm, "_rst_hi"}, hi, 32'd0);
            chk({nm, "_rst_lo"}, lo, 32'd0);
            break;
         end
         if (busy) busy_cnt++;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (hz_mthi > 0 && cyc == hz_mthi + 1) chk({nm, "_hold_hi"}, hi, hold_hi);
         if (cyc == hz_start) begin
            start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd3;
         end
         if (cyc == hz_mthi) begin
            mthi = 1'b1; wdata = 32'hDEAD_BEEF;
         end
         if (cyc == rst_at) rst = 1'b0;
         @(negedge clk);
         cyc++;
      end
      if (rst_at < 0) begin
         chk({nm, "_latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'd34);
         chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
         @(negedge clk);
         chk({nm, "_done_pulse"}, 32'(done), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; op = OP_MULT; a = '0; b = '0;
      mthi = 1'b0; mtlo = 1'b0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      rst = 1'b1;

      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1, -1, 32'd0, -1);
      run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, -1, -1, 32'd0, -1);
      run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, -1, 32'd0, -1);
      run_op("div_negb",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, -1, -1, 32'd0, -1);
      run_op("divu",      OP_DIVU,  32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003, -1, -1, 32'd0, -1);
      run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -1, -1, 32'd0, -1);
      run_op("divu_zero", OP_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, -1, -1, 32'd0, -1);
      run_op("div_zero",  OP_DIV,   32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF, -1, -1, 32'd0, -1);
      // Second start at cycle 5 and MTHI at cycle 10 must both be ignored; HI keeps the div_zero value.
      run_op("hazard",    OP_DIVU,  32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 5, 10, 32'hFFFF_FFF0, -1);

      @(negedge clk);
      mtlo = 1'b1; wdata = 32'h1234_5678;
      @(negedge clk);
      mtlo = 1'b0;
      chk("mtlo_lo", lo, 32'h1234_5678);
      chk("mtlo_hi", hi, 32'h0000_0002);

      @(negedge clk);
      mthi = 1'b1; wdata = 32'hCAFE_0001;
      @(negedge clk);
      mthi = 1'b0;
      chk("mthi_hi", hi, 32'hCAFE_0001);
      chk("mthi_lo", lo, 32'h1234_5678);

      run_op("rst_mid",   OP_MULTU, 32'd5,         32'd6,        32'd0,         32'd0,         -1, -1, 32'd0, 20);
      run_op("after_rst", OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, -1, -1, 32'd0, -1);

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Iterative multiply/divide unit holding the MIPS HI/LO architectural registers. It sits beside the register file: its operands come from the register file's two read ports (rs, rt), and its HI/LO outputs are selected onto the register-file write-data path for MFHI/MFLO. It executes MULT, MULTU, DIV and DIVU in 33 internal cycles, with a busy/done handshake so the controller can stall on a MFHI/MFLO hazard.

## Interface
Parameters:
- none (fixed 32-bit datapath)

Ports:
- clk  in  1  sole clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset, sampled on posedge clk
- start  in  1  request to begin an operation; accepted only in IDLE
- op  in  2  muldiv_op_t: MULT=0, MULTU=1, DIV=2, DIVU=3; sampled with start
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- mthi  in  1  write wdata to HI (MTHI)
- mtlo  in  1  write wdata to LO (MTLO)
- wdata  in  32  data for MTHI/MTLO
- busy  out  1  high while an operation is in progress (RUN or FIX)
- done  out  1  one-cycle pulse in the first cycle the new HI/LO are visible
- hi  out  32  HI register, driven directly from flop
- lo  out  32  LO register, driven directly from flop

## Operation
- Reset (rst==0 at posedge): state=IDLE, HI=LO=0, counter=0, busy=0, done=0. Reset takes effect in any state, including mid-operation, and discards the operation.
- States: IDLE, RUN, FIX.
- IDLE: if start==1, latch op, take operand magnitudes (|a|, |b| for signed ops, raw values for unsigned), record the result-sign bits, clear the counter, and go to RUN. Otherwise remain in IDLE.
- RUN: one step per cycle for 32 cycles (counter 0..31), then go to FIX.
  - Multiply: unsigned shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and a 32-bit remainder.
- FIX: apply the sign fix-up and write HI/LO, then go to IDLE.
  - MULT: negate the 64-bit product if sign(a)^sign(b). HI = product[63:32], LO = product[31:0].
  - DIV: negate the quotient if sign(a)^sign(b); the remainder takes the sign of the dividend. LO = quotient, HI = remainder.
  - DIVU/MULTU: no negation.
- Divide by zero (b==0, DIV or DIVU): HI=a, LO=0xFFFFFFFF. The operation still takes full latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- MTHI/MTLO in IDLE: HI/LO are written at the posedge. If mthi or mtlo is asserted in the same cycle as an accepted start, the write still happens and is later overwritten by the result.
- MTHI/MTLO while busy: ignored.
- start while busy: ignored. It is neither queued nor does it restart the operation.

## Timing
- Cycle 0: start=1 in IDLE.
- Cycles 1–32: RUN. busy=1 from cycle 1.
- Cycle 33: FIX. busy=1.
- Posedge ending cycle 33: HI/LO are updated.
- Cycle 34: busy=0, done=1, new HI/LO visible. The unit is back in IDLE and may accept a new start in cycle 34.
- The done pulse lasts exactly one cycle.
- MTHI/MTLO latency: 1 cycle (visible in the cycle after the write).
- hi/lo are stable whenever busy==1; they hold their previous values until FIX commits.
- Back-to-back operations: a start in cycle 34 produces done in cycle 68.

## Structure
- Shared package mips_pkg holds:
  - muldiv_op_t (2-bit enum)
  - muldiv_state_t (IDLE/RUN/FIX)
  - the constant MULDIV_ITERS=32
- Single module, no sub-module. The multiply and divide datapaths share the 64-bit working register and the 6-bit counter.

## Test plan
- Unsigned multiply: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF. Expect HI=0xFFFFFFFE, LO=0x00000001; done pulses in cycle 34; busy high in cycles 1–33.
- Signed multiply: MULT a=0xFFFFFFFD, b=7. Expect HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Signed and unsigned divide:
  - DIV a=0xFFFFFFF9, b=2: expect LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU a=7, b=2: expect LO=3, HI=1.
- Overflow and divide by zero:
  - DIV a=0x80000000, b=0xFFFFFFFF: expect LO=0x80000000, HI=0.
  - DIVU a=0x1234, b=0: expect HI=0x1234, LO=0xFFFFFFFF.
- Hazards and reset:
  - start a second op in cycle 5: ignored, result of the first op unchanged.
  - mthi in cycle 10: ignored.
  - rst=0 in cycle 20 of a later op: next cycle busy=0, done=0, HI=LO=0; a following start completes normally.
- Move-to: MTLO wdata=0x12345678 in IDLE. Expect lo=0x12345678 next cycle, hi unchanged.
